// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package hazard_ctrl_pkg;

  // Operand source selects for the E-stage ALU inputs
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // Register $0 is hard-wired to zero and never forwarded or hazarded on
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // M result wins over W because it is the younger write to the same register
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       regwrite_m,
    input logic [4:0] writereg_m,
    input logic       regwrite_w,
    input logic [4:0] writereg_w
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (src != REG_ZERO && regwrite_m && src == writereg_m) begin
      sel = FWD_M;
    end else if (src != REG_ZERO && regwrite_w && src == writereg_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// rtl/div_stall_fsm.sv - holds the pipeline while a multi-cycle divide occupies E
module div_stall_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic divstart_i,
  output logic divstall_o,
  output logic div_done_o
);

  // IDLE spends one stall cycle, so BUSY covers the remaining DIV_CYCLES-1 (cnt from DIV_CYCLES-2 down to 0)
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset abandons any divide in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, countdown and stall/done outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    divstall_o = 1'b0;
    div_done_o = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (divstart_i) begin
          divstall_o = 1'b1;
          state_d    = DIV_BUSY;
          cnt_d      = CNT_LOAD;
        end
      end
      DIV_BUSY: begin
        divstall_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DIV_DONE: begin
        // The finished divide is still in E here, so divstart is not a new request
        div_done_o = 1'b1;
        state_d    = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall and flush control for the 5-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       divstartE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       flushM,
  output logic       div_doneE
);

  logic divstall;
  logic div_done;
  logic lwstall;
  logic brstall;
  logic e_hits_d;
  logic m_hits_d;

  div_stall_fsm #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_div_stall_fsm (
    .clk       (clk),
    .rst_n     (reset),
    .divstart_i(divstartE),
    .divstall_o(divstall),
    .div_done_o(div_done)
  );

  // Hazard detection: load-use and branch operands not yet available in D
  always_comb begin
    e_hits_d = (writeregE != REG_ZERO) && (writeregE == rsD || writeregE == rtD);
    m_hits_d = (writeregM != REG_ZERO) && (writeregM == rsD || writeregM == rtD);
    lwstall  = MemtoRegE && e_hits_d;
    brstall  = BranchD && ((RegWriteE && e_hits_d) || (MemtoRegM && m_hits_d));
  end

  // Output drive; everything reads zero while reset is held
  always_comb begin
    forwardAE = FWD_REG;
    forwardBE = FWD_REG;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    div_doneE = 1'b0;
    if (reset) begin
      forwardAE = fwd_sel(rsE, RegWriteM, writeregM, RegWriteW, writeregW);
      forwardBE = fwd_sel(rtE, RegWriteM, writeregM, RegWriteW, writeregW);
      forwardAD = (rsD != REG_ZERO) && RegWriteM && (rsD == writeregM);
      forwardBD = (rtD != REG_ZERO) && RegWriteM && (rtD == writeregM);
      stallF    = lwstall || brstall || divstall;
      stallD    = lwstall || brstall || divstall;
      stallE    = divstall;
      // Holding D/E during a divide must not also bubble it
      flushE    = (lwstall || brstall) && !divstall;
      flushM    = divstall;
      div_doneE = div_done;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int DIV_N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, divstartE;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, stallF, stallD, stallE, flushE, flushM, div_doneE;

  int errors = 0;
  int checks = 0;

  // Reference divide model: stall cycles still owed after this one, and a done-pending flag
  int busy_left = 0;
  bit in_done   = 1'b0;

  int stall_cnt, done_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .DIV_CYCLES(DIV_N),
    .CNT_W     (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rsD      (rsD),
    .rtD      (rtD),
    .rsE      (rsE),
    .rtE      (rtE),
    .writeregE(writeregE),
    .writeregM(writeregM),
    .writeregW(writeregW),
    .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .MemtoRegM(MemtoRegM),
    .BranchD  (BranchD),
    .divstartE(divstartE),
    .forwardAE(forwardAE),
    .forwardBE(forwardBE),
    .forwardAD(forwardAD),
    .forwardBD(forwardBD),
    .stallF   (stallF),
    .stallD   (stallD),
    .stallE   (stallE),
    .flushE   (flushE),
    .flushM   (flushM),
    .div_doneE(div_doneE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (r != 0 && RegWriteM && r == writeregM) return 2'b10;
    if (r != 0 && RegWriteW && r == writeregW) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit uses(input logic [4:0] w);
    return (w != 0) && (w == rsD || w == rtD);
  endfunction

  task automatic check_outputs();
    bit lw, br, ds, dn;
    lw = 0; br = 0; ds = 0; dn = 0;
    if (!reset) begin
      busy_left = 0;
      in_done   = 1'b0;
    end else begin
      lw = MemtoRegE && uses(writeregE);
      br = BranchD && ((RegWriteE && uses(writeregE)) || (MemtoRegM && uses(writeregM)));
      ds = (busy_left > 0) || (!in_done && divstartE);
      dn = in_done;
    end
    check("forwardAE", 32'(forwardAE), reset ? 32'(ref_fwd(rsE)) : 32'd0);
    check("forwardBE", 32'(forwardBE), reset ? 32'(ref_fwd(rtE)) : 32'd0);
    check("forwardAD", 32'(forwardAD), 32'(reset && rsD != 0 && RegWriteM && rsD == writeregM));
    check("forwardBD", 32'(forwardBD), 32'(reset && rtD != 0 && RegWriteM && rtD == writeregM));
    check("stallF", 32'(stallF), 32'(lw || br || ds));
    check("stallD", 32'(stallD), 32'(lw || br || ds));
    check("stallE", 32'(stallE), 32'(ds));
    check("flushE", 32'(flushE), 32'((lw || br) && !ds));
    check("flushM", 32'(flushM), 32'(ds));
    check("div_doneE", 32'(div_doneE), 32'(dn));
    stall_cnt += int'(stallE);
    done_cnt  += int'(div_doneE);
    flush_cnt += int'(flushE);
  endtask

  // Check this cycle's outputs, advance the model across the edge, return at the falling edge
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    if (!reset) begin
      busy_left = 0;
      in_done   = 1'b0;
    end else if (in_done) begin
      in_done = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) in_done = 1'b1;
    end else if (divstartE) begin
      busy_left = DIV_N - 1;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; divstartE = 0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    tick();
    reset = 1'b1;

    // Forward priority M over W, then W alone, then $0
    RegWriteM = 1; writeregM = 8; RegWriteW = 1; writeregW = 8; rsE = 8;
    tick();
    check("fwd_m_prio", 32'(forwardAE), 32'd2);
    RegWriteM = 0;
    tick();
    check("fwd_w", 32'(forwardAE), 32'd1);
    rsE = 0;
    tick();
    check("fwd_zero", 32'(forwardAE), 32'd0);

    // Load-use
    clear_inputs();
    MemtoRegE = 1; writeregE = 9; rtD = 9;
    tick();
    check("lw_flushE", 32'(flushE), 32'd1);
    writeregE = 0;
    tick();

    // Branch on a load in M
    clear_inputs();
    BranchD = 1; rsD = 4; MemtoRegM = 1; writeregM = 4; RegWriteM = 1;
    tick();
    check("br_forwardAD", 32'(forwardAD), 32'd1);

    // Divide held high through DONE must not restart
    clear_inputs();
    divstartE = 1; stall_cnt = 0; done_cnt = 0;
    repeat (DIV_N) tick();
    tick();
    divstartE = 0;
    tick();
    check("div_stall_len", 32'(stall_cnt), 32'(DIV_N));
    check("div_done_cnt", 32'(done_cnt), 32'd1);

    // Divide overlapping a load-use hazard
    divstartE = 1; MemtoRegE = 1; writeregE = 9; rtD = 9; flush_cnt = 0;
    repeat (DIV_N) tick();
    tick();
    clear_inputs();
    tick();
    check("overlap_flush_cnt", 32'(flush_cnt), 32'd1);

    // Reset in the second BUSY cycle abandons the divide
    divstartE = 1; done_cnt = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_stallE", 32'(stallE), 32'd0);
    reset = 1'b1; divstartE = 0;
    repeat (DIV_N + 2) tick();
    check("rst_no_done", 32'(done_cnt), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3));
      writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom); MemtoRegM = 1'($urandom); BranchD = 1'($urandom);
      divstartE = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
